// File: rtl/reed_conditioner_pkg.sv
// Shared definitions for the reed-switch conditioner and the downstream speed path.
`default_nettype none

package reed_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_OPEN    = 2'd0,
    ST_CLOSING = 2'd1,
    ST_CLOSED  = 2'd2,
    ST_OPENING = 2'd3
  } reed_state_t;

  localparam int DEFAULT_DEBOUNCE_CYC = 8;
  localparam int DEFAULT_TIMEOUT_CYC  = 4000;

endpackage

`default_nettype wire

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
`default_nettype none

module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/reed_conditioner.sv
// Debounces the reed switch into one pulse per revolution, measures the
// revolution period in clock cycles and flags a stopped wheel.
`default_nettype none

module reed_conditioner
  import reed_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
  parameter int TIMEOUT_CYC  = DEFAULT_TIMEOUT_CYC,
  parameter int PERIOD_W     = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                reed_raw,
  output logic                reed_pulse,
  output logic                reed_level,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                stopped
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYC);
  localparam logic [DEB_W-1:0]    DEB_ONE  = DEB_W'(1);
  localparam logic [DEB_W-1:0]    DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [PERIOD_W-1:0] PER_LAST = PERIOD_W'(TIMEOUT_CYC - 1);

  logic                sync_q;
  reed_state_t         state;
  logic [DEB_W-1:0]    deb_cnt;
  logic [PERIOD_W-1:0] per_cnt;
  logic                accept;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (reed_raw),
    .q    (sync_q)
  );

  // Closure is accepted on the same edge the FSM enters CLOSED.
  assign accept = (state == ST_CLOSING) && sync_q && (deb_cnt == DEB_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_OPEN;
      deb_cnt    <= '0;
      reed_pulse <= 1'b0;
      reed_level <= 1'b0;
    end else begin
      reed_pulse <= 1'b0;
      case (state)
        ST_OPEN: begin
          if (sync_q) begin
            state   <= ST_CLOSING;
            deb_cnt <= DEB_ONE;
          end
        end
        ST_CLOSING: begin
          if (!sync_q) begin
            state <= ST_OPEN;
          end else if (deb_cnt == DEB_LAST) begin
            state      <= ST_CLOSED;
            reed_pulse <= 1'b1;
            reed_level <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        ST_CLOSED: begin
          if (!sync_q) begin
            state   <= ST_OPENING;
            deb_cnt <= DEB_ONE;
          end
        end
        ST_OPENING: begin
          if (sync_q) begin
            state <= ST_CLOSED;
          end else if (deb_cnt == DEB_LAST) begin
            state      <= ST_OPEN;
            reed_level <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_OPEN;
        end
      endcase
    end
  end

  // The first pulse after a stop only restarts timing; it has no reference point.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      per_cnt      <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      stopped      <= 1'b1;
    end else begin
      period_valid <= 1'b0;
      if (accept) begin
        per_cnt <= '0;
        if (stopped) begin
          stopped <= 1'b0;
        end else begin
          period       <= per_cnt + 1'b1;
          period_valid <= 1'b1;
        end
      end else if (!stopped) begin
        if (per_cnt == PER_LAST) begin
          stopped <= 1'b1;
          period  <= '0;
        end else begin
          per_cnt <= per_cnt + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reed_conditioner.sv
// Self-checking bench: directed scenarios plus random bounce traffic against a run-length model.
`default_nettype none

module tb_reed_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam int TMO  = 4000;
  localparam int PW   = 16;

  logic          clock    = 1'b0;
  logic          reset    = 1'b0;
  logic          reed_raw = 1'b0;
  logic          reed_pulse;
  logic          reed_level;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          stopped;

  int total = 0;
  int bad   = 0;
  int pulse_cnt = 0;

  always #5 clock = ~clock;

  reed_conditioner #(
    .SYNC_STAGES (SYNC),
    .DEBOUNCE_CYC(DEB),
    .TIMEOUT_CYC (TMO),
    .PERIOD_W    (PW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .reed_raw    (reed_raw),
    .reed_pulse  (reed_pulse),
    .reed_level  (reed_level),
    .period      (period),
    .period_valid(period_valid),
    .stopped     (stopped)
  );

  // Model: the synchronised sample seen at edge k is reed_raw from edge k-SYNC.
  // The debounced level flips once DEB consecutive samples disagree with it.
  bit hist[$];
  bit s_now;
  int run_len   = DEB;
  bit run_val   = 1'b0;
  bit m_level   = 1'b0;
  bit m_pulse   = 1'b0;
  bit m_valid   = 1'b0;
  bit m_stopped = 1'b1;
  int m_period  = 0;
  int edge_n    = 0;
  int last_edge = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist.delete();
      run_len   = DEB;
      run_val   = 1'b0;
      m_level   = 1'b0;
      m_pulse   = 1'b0;
      m_valid   = 1'b0;
      m_stopped = 1'b1;
      m_period  = 0;
    end else begin
      edge_n++;
      s_now = (hist.size() == SYNC) ? hist[0] : 1'b0;
      hist.push_back(reed_raw);
      if (hist.size() > SYNC) void'(hist.pop_front());
      if (s_now == run_val) run_len++;
      else begin
        run_val = s_now;
        run_len = 1;
      end
      m_pulse = 1'b0;
      m_valid = 1'b0;
      if (run_len >= DEB && run_val != m_level) begin
        m_level = run_val;
        m_pulse = run_val;
      end
      if (m_pulse) begin
        if (m_stopped) m_stopped = 1'b0;
        else begin
          m_period = edge_n - last_edge;
          m_valid  = 1'b1;
        end
        last_edge = edge_n;
      end else if (!m_stopped && (edge_n - last_edge) == TMO) begin
        m_stopped = 1'b1;
        m_period  = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reed_pulse === 1'b1) pulse_cnt++;
    check("pulse", {31'd0, reed_pulse}, {31'd0, m_pulse});
    check("level", {31'd0, reed_level}, {31'd0, m_level});
    check("valid", {31'd0, period_valid}, {31'd0, m_valid});
    check("stopped", {31'd0, stopped}, {31'd0, m_stopped});
    check("period", {16'd0, period}, m_period);
  end

  // Counts negedges until reed_pulse; index 0 is just after the first edge sampling new input.
  task automatic wait_pulse(input int limit, output int n);
    n = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (reed_pulse === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Called on the negedge right after a pulse; produces the next pulse exactly gap edges later.
  task automatic pulse_after(input int gap);
    int n;
    reed_raw = 1'b0;
    repeat (gap - 10) @(negedge clock);
    reed_raw = 1'b1;
    wait_pulse(20, n);
    check("gap_latency", n, 9);
    check("gap_period", {16'd0, period}, gap);
    check("gap_valid", {31'd0, period_valid}, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pulse"}, {31'd0, reed_pulse}, 0);
    check({tag, "_level"}, {31'd0, reed_level}, 0);
    check({tag, "_period"}, {16'd0, period}, 0);
    check({tag, "_valid"}, {31'd0, period_valid}, 0);
    check({tag, "_stopped"}, {31'd0, stopped}, 1);
  endtask

  initial begin
    int n;
    int snap;
    repeat (3) @(negedge clock);
    check_reset_values("por");

    // Clean closure straight out of reset.
    reset    = 1'b1;
    reed_raw = 1'b1;
    wait_pulse(30, n);
    check("clean_latency", n, 9);
    check("clean_level", {31'd0, reed_level}, 1);
    check("clean_valid", {31'd0, period_valid}, 0);
    check("clean_stopped", {31'd0, stopped}, 0);

    pulse_after(100);
    pulse_after(200);

    // Bounce of 3-cycle runs, then a solid closure.
    reed_raw = 1'b0;
    repeat (20) @(negedge clock);
    snap = pulse_cnt;
    repeat (5) begin
      reed_raw = 1'b1;
      repeat (3) @(negedge clock);
      reed_raw = 1'b0;
      repeat (3) @(negedge clock);
    end
    check("bounce_no_pulse", pulse_cnt - snap, 0);
    reed_raw = 1'b1;
    wait_pulse(30, n);
    check("bounce_latency", n, 9);

    // Short open glitches while closed.
    repeat (10) @(negedge clock);
    snap = pulse_cnt;
    for (int g = 1; g <= 7; g++) begin
      reed_raw = 1'b0;
      repeat (g) @(negedge clock);
      reed_raw = 1'b1;
      repeat (12) @(negedge clock);
    end
    check("glitch_no_pulse", pulse_cnt - snap, 0);
    check("glitch_level", {31'd0, reed_level}, 1);

    // Timeout, restart without reference, then a fresh measurement.
    reed_raw = 1'b0;
    repeat (20) @(negedge clock);
    reed_raw = 1'b1;
    wait_pulse(30, n);
    check("pre_timeout_latency", n, 9);
    reed_raw = 1'b0;
    n = -1;
    for (int i = 1; i <= 4100; i++) begin
      @(negedge clock);
      if (stopped === 1'b1) begin
        n = i;
        break;
      end
    end
    check("timeout_edges", n, 4000);
    check("timeout_period", {16'd0, period}, 0);
    reed_raw = 1'b1;
    wait_pulse(30, n);
    check("restart_latency", n, 9);
    check("restart_valid", {31'd0, period_valid}, 0);
    check("restart_stopped", {31'd0, stopped}, 0);
    pulse_after(500);

    // Pulse landing on the timeout edge wins.
    pulse_after(4000);
    check("coincide_stopped", {31'd0, stopped}, 0);
    pulse_after(3999);

    // Random bouncy traffic.
    for (int k = 0; k < 400; k++) begin
      reed_raw = ($urandom_range(0, 1) == 1);
      repeat ($urandom_range(1, 14)) @(negedge clock);
    end

    // Asynchronous reset in the middle of a closing debounce.
    reed_raw = 1'b0;
    repeat (20) @(negedge clock);
    reed_raw = 1'b1;
    repeat (5) @(negedge clock);
    #2 reset = 1'b0;
    #1 check_reset_values("async");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    wait_pulse(30, n);
    check("release_latency", n, 9);

    repeat (5) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
